// File: rtl/store_byte_rmw.sv
// Narrows a 16-bit register value for SB and read-modify-writes it into word memory; SW passes through.
// Optional build macro TRUNC_CHECK_EN flags SB values whose upper byte is non-zero.
module store_byte_rmw #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic        st_size,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  output logic        st_ready,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_ERR} state_t;

  state_t      r_state;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_size;
  logic [15:0] r_merge;
  logic        r_en;
  logic        r_wr;
  logic        r_done;
  logic        r_err;

  logic        w_hi_lane;
  logic [15:0] w_merged;
  logic        w_trunc;

  // Upper lane is picked when the address LSB differs from the endian setting.
  assign w_hi_lane = r_addr[0] ^ BIG_ENDIAN;
  assign w_merged  = w_hi_lane ? {r_data[7:0], mem_rdata[7:0]}
                               : {mem_rdata[15:8], r_data[7:0]};

`ifdef TRUNC_CHECK_EN
  assign w_trunc = (r_data[15:8] != 8'h00);
`else
  assign w_trunc = 1'b0;
`endif

  assign st_ready  = (r_state == S_IDLE);
  assign st_done   = r_done;
  assign st_err    = r_err;
  assign mem_en    = r_en;
  assign mem_wr    = r_wr;
  assign mem_addr  = {r_addr[15:1], 1'b0};
  // Both sources are registers, so the write data is stable for the whole WR cycle.
  assign mem_wdata = r_size ? r_data : r_merge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_size  <= 1'b0;
      r_merge <= 16'h0000;
      r_en    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (st_valid) begin
            r_addr <= st_addr;
            r_data <= st_data;
            r_size <= st_size;
            if (!st_size) begin
              r_state <= S_RD;
              r_en    <= 1'b1;
            end else if (!st_addr[0]) begin
              r_state <= S_WR;
              r_en    <= 1'b1;
              r_wr    <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state <= S_MRG;
        end
        S_MRG: begin
          // Read data is valid in this cycle; the merged word is driven in WR.
          r_merge <= w_merged;
          r_state <= S_WR;
          r_en    <= 1'b1;
          r_wr    <= 1'b1;
          r_done  <= 1'b1;
          r_err   <= w_trunc;
        end
        S_WR:    r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_byte_rmw.sv
// Directed bench: little- and big-endian instances share stimulus, each with its own word memory.
module tb_store_byte_rmw;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_size;
  logic [15:0] st_addr;
  logic [15:0] st_data;

  logic        le_ready, le_done, le_err, le_en, le_wr;
  logic [15:0] le_addr, le_wdata, le_rdata;
  logic        be_ready, be_done, be_err, be_en, be_wr;
  logic [15:0] be_addr, be_wdata, be_rdata;

  logic [15:0] mem_le [0:127];
  logic [15:0] mem_be [0:127];
  logic        pre_we = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [15:0] pre_val = 16'h0000;

  int rd_le = 0, wr_le = 0, done_le = 0, rd_be = 0, wr_be = 0;
  logic [15:0] last_wa_le = 16'h0000;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_byte_rmw #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_ready(le_ready),
    .st_done(le_done), .st_err(le_err), .mem_en(le_en), .mem_wr(le_wr),
    .mem_addr(le_addr), .mem_wdata(le_wdata), .mem_rdata(le_rdata)
  );

  store_byte_rmw #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .st_ready(be_ready),
    .st_done(be_done), .st_err(be_err), .mem_en(be_en), .mem_wr(be_wr),
    .mem_addr(be_addr), .mem_wdata(be_wdata), .mem_rdata(be_rdata)
  );

  // Memory models: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (pre_we) begin
      mem_le[pre_idx] <= pre_val;
      mem_be[pre_idx] <= pre_val;
    end
    if (le_en && !le_wr) begin
      le_rdata <= mem_le[le_addr[7:1]];
      rd_le = rd_le + 1;
    end
    if (le_en && le_wr) begin
      mem_le[le_addr[7:1]] <= le_wdata;
      wr_le = wr_le + 1;
      last_wa_le = le_addr;
    end
    if (be_en && !be_wr) begin
      be_rdata <= mem_be[be_addr[7:1]];
      rd_be = rd_be + 1;
    end
    if (be_en && be_wr) begin
      mem_be[be_addr[7:1]] <= be_wdata;
      wr_be = wr_be + 1;
    end
    if (le_done) done_le = done_le + 1;
  end

  typedef struct {
    logic        size;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] init;
    logic [15:0] exp_le;
    logic [15:0] exp_be;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(logic size, logic [15:0] addr, logic [15:0] data,
                              logic [15:0] init, logic [15:0] exp_le,
                              logic [15:0] exp_be, logic exp_err);
    vec_t v;
    v.size = size; v.addr = addr; v.data = data; v.init = init;
    v.exp_le = exp_le; v.exp_be = exp_be; v.exp_err = exp_err;
    if (!size) begin
      v.exp_lat = 3; v.exp_rd = 1; v.exp_wr = 1;
    end else if (!addr[0]) begin
      v.exp_lat = 1; v.exp_rd = 0; v.exp_wr = 1;
    end else begin
      v.exp_lat = 1; v.exp_rd = 0; v.exp_wr = 0;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] addr, input logic [15:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = addr[7:1]; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat_le, lat_be, rd0, wr0, rdb0, wrb0;
    logic err_le, err_be;
    preload(v.addr, v.init);
    chk({tag, ".ready"}, le_ready, 1);
    rd0 = rd_le; wr0 = wr_le; rdb0 = rd_be; wrb0 = wr_be;
    st_valid = 1'b1; st_size = v.size; st_addr = v.addr; st_data = v.data;
    lat_le = 0; lat_be = 0; err_le = 1'b0; err_be = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) st_valid = 1'b0;
      if (le_done && lat_le == 0) begin lat_le = c; err_le = le_err; end
      if (be_done && lat_be == 0) begin lat_be = c; err_be = be_err; end
    end
    chk({tag, ".lat_le"}, lat_le, v.exp_lat);
    chk({tag, ".lat_be"}, lat_be, v.exp_lat);
    chk({tag, ".err_le"}, err_le, v.exp_err);
    chk({tag, ".err_be"}, err_be, v.exp_err);
    chk({tag, ".reads"}, rd_le - rd0, v.exp_rd);
    chk({tag, ".writes"}, wr_le - wr0, v.exp_wr);
    chk({tag, ".reads_be"}, rd_be - rdb0, v.exp_rd);
    chk({tag, ".writes_be"}, wr_be - wrb0, v.exp_wr);
    if (v.exp_wr != 0) chk({tag, ".waddr"}, last_wa_le, {v.addr[15:1], 1'b0});
    chk({tag, ".mem_le"}, mem_le[v.addr[7:1]], v.exp_le);
    chk({tag, ".mem_be"}, mem_be[v.addr[7:1]], v.exp_be);
  endtask

  localparam logic TRUNC_ERR =
`ifdef TRUNC_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  vec_t vecs[7];
  vec_t v_mid;
  int   wr0, done0;

  initial begin
    vecs[0] = mk(1'b0, 16'h0040, 16'h0012, 16'hABCD, 16'hAB12, 16'h12CD, 1'b0);
    vecs[1] = mk(1'b0, 16'h0041, 16'h0077, 16'hABCD, 16'h77CD, 16'hAB77, 1'b0);
    vecs[2] = mk(1'b1, 16'h0010, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 1'b0);
    vecs[3] = mk(1'b1, 16'h0011, 16'h5555, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1);
    vecs[4] = mk(1'b0, 16'h0020, 16'hFF34, 16'h0000, 16'h0034, 16'h3400, TRUNC_ERR);
    vecs[5] = mk(1'b0, 16'h0021, 16'h00C3, 16'h1111, 16'hC311, 16'h11C3, 1'b0);
    vecs[6] = mk(1'b1, 16'h00FE, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);

    // Reset held with a pending request: nothing is accepted.
    rst = 1'b0; st_valid = 1'b1; st_size = 1'b0; st_addr = 16'h0040; st_data = 16'h0012;
    @(negedge clk);
    chk("rst.ready", le_ready, 1);
    chk("rst.mem_en", le_en, 0);
    chk("rst.done", le_done, 0);
    chk("rst.err", le_err, 0);
    @(negedge clk);
    chk("rst.ready2", le_ready, 1);
    chk("rst.mem_en2", le_en, 0);
    chk("rst.reads", rd_le, 0);
    st_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst.idle_en", le_en, 0);

    for (int i = 0; i < 7; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset arrives while the RMW sits in MRG.
    v_mid = mk(1'b0, 16'h0030, 16'h00EE, 16'h5A5A, 16'h5AEE, 16'hEE5A, 1'b0);
    preload(16'h0030, 16'h5A5A);
    wr0 = wr_le; done0 = done_le;
    st_valid = 1'b1; st_size = 1'b0; st_addr = 16'h0030; st_data = 16'h00EE;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid.ready", le_ready, 1);
    chk("mid.mem_en", le_en, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid.writes", wr_le - wr0, 0);
    chk("mid.done", done_le - done0, 0);
    chk("mid.mem", mem_le[7'h18], 16'h5A5A);
    apply(v_mid, "mid.retry");

    // Back-to-back: valid held for 6 edges gives exactly 3 aligned SW accepts.
    preload(16'h0050, 16'h0000);
    wr0 = wr_le; done0 = done_le;
    st_valid = 1'b1; st_size = 1'b1; st_addr = 16'h0050; st_data = 16'h0001;
    repeat (6) @(negedge clk);
    st_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b.writes", wr_le - wr0, 3);
    chk("b2b.done", done_le - done0, 3);
    chk("b2b.mem", mem_le[7'h28], 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
